// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM state and
// accept-type enums, CSR addresses, cause codes, interrupt bit positions
// and mstatus field positions.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    REDIRECT
  } state_e;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_IRQ,
    ACC_EBREAK,
    ACC_ECALL,
    ACC_MRET
  } acc_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Exception codes; the interrupt flag (MSB) is added by the encoder.
  localparam int unsigned CAUSE_MSI        = 3;
  localparam int unsigned CAUSE_MTI        = 7;
  localparam int unsigned CAUSE_MEI        = 11;
  localparam int unsigned CAUSE_BREAKPOINT = 3;
  localparam int unsigned CAUSE_ECALL_M    = 11;

  // mie/mip bit positions.
  localparam int unsigned IRQ_MSI_BIT = 3;
  localparam int unsigned IRQ_MTI_BIT = 7;
  localparam int unsigned IRQ_MEI_BIT = 11;

  // mstatus field positions.
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_M              = 2'b11;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_cause_enc.sv
// Combinational request arbiter: picks at most one request per cycle
// (interrupt > ebreak > ecall > mret) and produces its mcause value.
//   inst_valid_i          commit-stage instruction valid
//   ecall_i/ebreak_i/mret_i  decoded system instructions
//   mstatus_mie_i         mstatus.MIE
//   mie_i, mip_i          interrupt enable / pending CSRs
//   acc_o                 accepted request type (ACC_NONE if nothing)
//   cause_o               mcause value for the accepted trap (0 for mret)
module trap_cause_enc
  import trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            inst_valid_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mip_i,
  output acc_e            acc_o,
  output logic [XLEN-1:0] cause_o
);

  logic [XLEN-1:0] irq_act;
  logic            irq_pend;

  assign irq_act  = mie_i & mip_i;
  assign irq_pend = mstatus_mie_i && (irq_act != '0);

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    acc_o   = ACC_NONE;
    cause_o = '0;
    if (inst_valid_i) begin
      if (irq_pend) begin
        acc_o            = ACC_IRQ;
        cause_o[XLEN-1]  = 1'b1;
        // Enabled bits outside MEI/MSI/MTI fall through to the timer code.
        if (irq_act[IRQ_MEI_BIT])      cause_o[XLEN-2:0] = (XLEN-1)'(CAUSE_MEI);
        else if (irq_act[IRQ_MSI_BIT]) cause_o[XLEN-2:0] = (XLEN-1)'(CAUSE_MSI);
        else                           cause_o[XLEN-2:0] = (XLEN-1)'(CAUSE_MTI);
      end else if (ebreak_i) begin
        acc_o   = ACC_EBREAK;
        cause_o = XLEN'(CAUSE_BREAKPOINT);
      end else if (ecall_i) begin
        acc_o   = ACC_ECALL;
        cause_o = XLEN'(CAUSE_ECALL_M);
      end else if (mret_i) begin
        acc_o = ACC_MRET;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer. Accepts one request in IDLE,
// snapshots the architectural state, then drives the CSR write port one
// register per cycle and finally holds a fetch redirect until accepted.
//   clk, rst                 clock, synchronous active-high reset
//   inst_valid, pc           commit-stage instruction and its PC
//   ecall, ebreak, mret      decoded commit-stage system instructions
//   csr_mstatus..csr_mepc    current CSR values
//   csr_w_en/addr/data       CSR write port (owned while busy)
//   busy                     stall pipeline / gate pipeline CSR writes
//   flush                    one-cycle pulse after each accepted request
//   redirect_valid/pc/ready  fetch redirect handshake
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter bit MTVEC_VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            mret,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [XLEN-1:0] csr_mip,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            csr_w_en,
  output logic [11:0]     csr_w_addr,
  output logic [XLEN-1:0] csr_w_data,
  output logic            busy,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic            is_mret_q, is_mret_d;
  logic            accept;

  acc_e            acc;
  logic [XLEN-1:0] cause;

  trap_cause_enc #(.XLEN(XLEN)) u_cause_enc (
    .inst_valid_i  (inst_valid),
    .ecall_i       (ecall),
    .ebreak_i      (ebreak),
    .mret_i        (mret),
    .mstatus_mie_i (csr_mstatus[MSTATUS_MIE]),
    .mie_i         (csr_mie),
    .mip_i         (csr_mip),
    .acc_o         (acc),
    .cause_o       (cause)
  );

  // Next state and snapshot capture. Requests are only looked at in IDLE,
  // so anything raised mid-sequence is simply re-evaluated afterwards.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    is_mret_d = is_mret_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc != ACC_NONE) begin
          accept    = 1'b1;
          pc_d      = pc;
          cause_d   = cause;
          mstatus_d = csr_mstatus;
          mtvec_d   = csr_mtvec;
          mepc_d    = csr_mepc;
          is_mret_d = (acc == ACC_MRET);
          state_d   = (acc == ACC_MRET) ? W_MSTATUS : W_MEPC;
        end
      end
      W_MEPC:    state_d = W_MCAUSE;
      W_MCAUSE:  state_d = W_MSTATUS;
      W_MSTATUS: state_d = REDIRECT;
      REDIRECT:  if (redirect_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Derived write data and redirect target, computed from the snapshot only.
  logic [XLEN-1:0] mstatus_wr, mtvec_base, target;

  always_comb begin
    mstatus_wr = mstatus_d;
    if (is_mret_d) begin
      mstatus_wr[MSTATUS_MIE]  = mstatus_d[MSTATUS_MPIE];
      mstatus_wr[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_wr[MSTATUS_MPIE] = mstatus_d[MSTATUS_MIE];
      mstatus_wr[MSTATUS_MIE]  = 1'b0;
    end
    mstatus_wr[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;

    mtvec_base = {mtvec_d[XLEN-1:2], 2'b00};
    if (is_mret_d)
      target = mepc_d;
    else if (MTVEC_VEC_EN && (mtvec_d[1:0] == MTVEC_MODE_VECTORED) && cause_d[XLEN-1])
      target = mtvec_base + {cause_d[XLEN-3:0], 2'b00};  // base + 4*code
    else
      target = mtvec_base;
  end

  // Output values for the state being entered, so the ports are registers.
  logic            w_en_d, rv_d;
  logic [11:0]     w_addr_d;
  logic [XLEN-1:0] w_data_d, rpc_d;

  always_comb begin
    w_en_d   = 1'b0;
    w_addr_d = '0;
    w_data_d = '0;
    rv_d     = 1'b0;
    rpc_d    = '0;
    case (state_d)
      W_MEPC:    begin w_en_d = 1'b1; w_addr_d = CSR_MEPC;    w_data_d = pc_d;       end
      W_MCAUSE:  begin w_en_d = 1'b1; w_addr_d = CSR_MCAUSE;  w_data_d = cause_d;    end
      W_MSTATUS: begin w_en_d = 1'b1; w_addr_d = CSR_MSTATUS; w_data_d = mstatus_wr; end
      REDIRECT:  begin rv_d   = 1'b1; rpc_d    = target; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshots are cleared on reset too, so an aborted
      // sequence leaves no stale trap state behind.
      state_q        <= IDLE;
      pc_q           <= '0;
      cause_q        <= '0;
      mstatus_q      <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      is_mret_q      <= 1'b0;
      csr_w_en       <= 1'b0;
      csr_w_addr     <= '0;
      csr_w_data     <= '0;
      busy           <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      cause_q        <= cause_d;
      mstatus_q      <= mstatus_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      is_mret_q      <= is_mret_d;
      csr_w_en       <= w_en_d;
      csr_w_addr     <= w_addr_d;
      csr_w_data     <= w_data_d;
      busy           <= (state_d != IDLE);
      flush          <= accept;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
    end
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the data width of the CSR and PC.
REQ-002 SHALL have parameter MTVEC_VEC_EN, default 1, which enables vectored mtvec mode (mtvec[1:0]==1) for interrupts.
REQ-003 SHALL provide the following ports; the design uses one clock, and the reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  reset
- inst_valid  in  1  commit-stage instruction valid
- pc  in  XLEN  commit-stage PC
- ecall, ebreak, mret  in  1 each  decoded commit-stage system instructions
- csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc  in  XLEN each  current CSR values
- csr_w_en  out  1  CSR write-port enable (owned by this block while busy)
- csr_w_addr  out  12  CSR write address
- csr_w_data  out  XLEN  CSR write data
- busy  out  1  stall pipeline and gate pipeline CSR writes
- flush  out  1  one-cycle flush pulse
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  XLEN  redirect target
- redirect_ready  in  1  fetch accepts the redirect

Function
REQ-004 SHALL implement the FSM states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT, with Moore outputs decoded from state and registered data.
REQ-005 SHALL define interrupt pending as mstatus.MIE(bit 3) && (mie & mip) != 0.
REQ-006 SHALL apply accept priority, in IDLE with inst_valid=1 only: interrupt > ebreak > ecall > mret; at most one request is accepted per cycle.
REQ-007 SHALL encode the interrupt cause as MEI(bit 11)=0x8000..000B > MSI(bit 3)=0x8000..0003 > MTI(bit 7)=0x8000..0007; ebreak cause SHALL be 3 and ecall cause SHALL be 11.
REQ-008 SHALL latch pc, cause, mstatus, mtvec and mepc into snapshot registers on the accept edge; all later writes SHALL use the snapshot only.
REQ-009 For a trap accepted at the end of cycle T, the block SHALL step: T+1 W_MEPC (write 0x341 <= pc, flush=1), T+2 W_MCAUSE (write 0x342 <= cause), T+3 W_MSTATUS (write 0x300), T+4 REDIRECT.
REQ-010 On trap entry, the mstatus write data SHALL be the snapshot with MPIE(bit 7) <= MIE, MIE <= 0, and MPP(bits 12:11) <= 2'b11.
REQ-011 For an mret accepted at T, the block SHALL step: T+1 W_MSTATUS (flush=1; MIE <= MPIE, MPIE <= 1, MPP <= 2'b11), T+2 REDIRECT to the snapshot mepc.
REQ-012 The trap redirect_pc SHALL be mtvec & ~3; if MTVEC_VEC_EN=1, mtvec[1:0]==1 and the trap is an interrupt, it SHALL instead be (mtvec & ~3) + 4*cause[XLEN-2:0].
REQ-013 In REDIRECT, redirect_valid SHALL be 1 with redirect_pc held stable until redirect_ready=1; on that cycle the FSM SHALL go to IDLE.
REQ-014 csr_w_en SHALL be 1 exactly in the W_* states, and csr_w_addr/csr_w_data SHALL be 0 elsewhere.
REQ-015 busy SHALL be 1 in every state except IDLE; requests arriving while busy SHALL be ignored, not queued.
REQ-016 flush SHALL be a single-cycle pulse per accepted request.
REQ-017 A request with inst_valid=0 SHALL NOT be accepted.
REQ-018 Pending interrupts SHALL be re-evaluated only in IDLE, so an interrupt raised mid-sequence is taken after return to IDLE if still pending and enabled.

Reset
REQ-019 rst=1 at any clock edge SHALL force IDLE, clear all snapshots, and drive every output to 0 on the next cycle.
REQ-020 A reset in mid-sequence SHALL abort the sequence, with no further CSR write or redirect issued.

Structure
REQ-021 A shared package trap_pkg SHALL hold the state enum, CSR addresses (0x300, 0x341, 0x342), cause constants, and mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
REQ-022 A single combinational sub-module, trap_cause_enc, SHALL produce the accept type and the cause from the requests, mie, mip and mstatus.
REQ-023 The RTL SHALL be one FSM plus snapshot registers, with no memories.

Verification
REQ-024 Test: ecall at pc=0x8000_0100, mtvec=0x8000_0000, mstatus=0x8 -> writes mepc=0x8000_0100, mcause=11, mstatus=0x1880; then redirect_pc=0x8000_0000 at T+4.
REQ-025 Test: mtip with mie=0x80, MIE=1 and mtvec=0x8000_0001 (vectored) -> mcause=0x8000_0000_0000_0007 and redirect_pc=0x8000_001C.
REQ-026 Test: mret with mstatus=0x1880 and mepc=0x8000_0104 -> mstatus write 0x1888, then redirect_pc=0x8000_0104 at T+2.
REQ-027 Test: redirect_ready held low for 3 cycles -> redirect_valid and redirect_pc stay stable, and IDLE is reached on the cycle after ready.
REQ-028 Test: ecall and msip asserted together with MIE=1 and mie=0x8 -> the interrupt wins with mcause=0x8000_0000_0000_0003; ecall again during busy is ignored.
REQ-029 Test: rst pulsed in W_MCAUSE -> no mstatus write and no redirect occur, and all outputs are 0 afterwards.
